// File: rtl/mem_io_ctl_if.sv
// rtl/mem_io_ctl_if.sv - control/bus/SRAM signal bundle for mem_io_ctl
// Purpose: groups every non-clock, non-reset signal of mem_io_ctl.
// Ports (slave = the controller):
//   in : LD_MAR, LD_MDR, Mem_OE, Mem_WE, Bus[15:0], SRAM_Data_In[15:0], Switches[15:0]
//   out: MAR[15:0], MDR[15:0], SRAM_ADDR[19:0], SRAM_OE_N, SRAM_WE_N,
//        SRAM_Data_Out[15:0], SRAM_Drive, HEX_Value[15:0], Bus_Err
interface mem_io_ctl_if;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Bus;
    logic [15:0] SRAM_Data_In;
    logic [15:0] Switches;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] SRAM_Data_Out;
    logic        SRAM_Drive;
    logic [15:0] HEX_Value;
    logic        Bus_Err;

    modport slave (
        input  LD_MAR, LD_MDR, Mem_OE, Mem_WE, Bus, SRAM_Data_In, Switches,
        output MAR, MDR, SRAM_ADDR, SRAM_OE_N, SRAM_WE_N, SRAM_Data_Out,
               SRAM_Drive, HEX_Value, Bus_Err
    );

    modport master (
        output LD_MAR, LD_MDR, Mem_OE, Mem_WE, Bus, SRAM_Data_In, Switches,
        input  MAR, MDR, SRAM_ADDR, SRAM_OE_N, SRAM_WE_N, SRAM_Data_Out,
               SRAM_Drive, HEX_Value, Bus_Err
    );
endinterface

// File: rtl/mem_io_ctl.sv
// rtl/mem_io_ctl.sv - MAR/MDR memory and memory-mapped I/O access controller
// Purpose: sequences SRAM reads/writes requested by the control unit, maps
//          address 16'hFFFF to the switches (read) and hex display (write),
//          and flags protocol violations in a sticky Bus_Err.
// Ports:
//   Clk   - rising-edge clock
//   Reset - synchronous active-high reset
//   io    - mem_io_ctl_if.slave bundle (control strobes, bus, SRAM, I/O)
module mem_io_ctl (
    input  logic          Clk,
    input  logic          Reset,
    mem_io_ctl_if.slave   io
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2} state_t;

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] hex_q, hex_d;
    logic        bus_err_q, bus_err_d;
    logic        is_io;
    logic        sram_oe_n, sram_we_n, sram_drive;

    assign is_io = (mar_q == 16'hFFFF);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; write wins when both requests arrive together
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!io.Mem_WE)      state_d = WR1;
                else if (!io.Mem_OE) state_d = RD1;
            end
            RD1:     state_d = io.Mem_OE ? IDLE : RD2;
            RD2:     state_d = io.Mem_OE ? IDLE : RD2;
            WR1:     state_d = io.Mem_WE ? IDLE : WR2;
            WR2:     state_d = io.Mem_WE ? IDLE : WR2;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: SRAM strobes are suppressed for the I/O address
    always_comb begin
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_drive = 1'b0;
        unique case (state_q)
            RD1, RD2: sram_oe_n = is_io;
            WR1:      sram_drive = 1'b1;
            WR2: begin
                sram_drive = 1'b1;
                sram_we_n  = is_io;
            end
            default: ;
        endcase
    end

    // Datapath registers and error detection
    always_comb begin
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        hex_d     = hex_q;
        bus_err_d = bus_err_q;

        if (io.LD_MAR) begin
            mar_d = io.Bus;
            if (state_q != IDLE) bus_err_d = 1'b1;
        end

        if (io.LD_MDR) begin
            if (io.Mem_OE) begin
                mdr_d = io.Bus;
            end else begin
                mdr_d = is_io ? io.Switches : io.SRAM_Data_In;
                // Memory data is not yet valid before RD2
                if (state_q == IDLE || state_q == RD1) bus_err_d = 1'b1;
            end
        end

        // The WR1->WR2 edge happens once per write, so the display latches
        // exactly once even if WR2 is held for many cycles.
        if (state_q == WR1 && !io.Mem_WE && is_io) hex_d = mdr_q;

        if (state_q == WR1 && io.Mem_WE) bus_err_d = 1'b1;
        if (state_q == IDLE && !io.Mem_WE && !io.Mem_OE) bus_err_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mar_q     <= 16'h0000;
            mdr_q     <= 16'h0000;
            hex_q     <= 16'h0000;
            bus_err_q <= 1'b0;
        end else begin
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            hex_q     <= hex_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign io.MAR           = mar_q;
    assign io.MDR           = mdr_q;
    assign io.SRAM_ADDR     = {4'h0, mar_q};
    assign io.SRAM_Data_Out = mdr_q;
    assign io.HEX_Value     = hex_q;
    assign io.Bus_Err       = bus_err_q;
    assign io.SRAM_OE_N     = sram_oe_n;
    assign io.SRAM_WE_N     = sram_we_n;
    assign io.SRAM_Drive    = sram_drive;
endmodule
